// File: rtl/mem_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes, FSM states and
// the legal response-latency range.
package mem_pkg;
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  function automatic bit lat_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction
endpackage

// File: rtl/data_mem_bytelane_if.sv
// Request/response bus between the datapath (master) and the data memory (slave).
interface data_mem_bytelane_if;
  logic        Req;
  logic        WriteEnable;
  logic [1:0]  Size;
  logic        Signed;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        Ready;
  logic        Valid;
  logic [31:0] ReadData;
  logic        Error;

  modport master (
    output Req, WriteEnable, Size, Signed, Address, WriteData,
    input  Ready, Valid, ReadData, Error
  );

  modport slave (
    input  Req, WriteEnable, Size, Signed, Address, WriteData,
    output Ready, Valid, ReadData, Error
  );
endinterface

// File: rtl/load_align.sv
// Combinational lane selector: picks and extends the addressed byte/half/word,
// flags misaligned or reserved accesses, and reports which byte lanes are touched.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data,
  output logic [3:0]  lanes,
  output logic        misalign
);
  logic [31:0] shifted;

  assign shifted = word >> {addr_lo, 3'b000};

  always_comb begin
    misalign = 1'b0;
    lanes    = '0;
    data     = '0;
    case (size)
      SIZE_B: begin
        lanes = 4'b0001 << addr_lo;
        data  = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        misalign = addr_lo[0];
        lanes    = 4'b0011 << addr_lo;
        data     = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      SIZE_W: begin
        misalign = |addr_lo;
        lanes    = 4'b1111;
        data     = word;
      end
      default: misalign = 1'b1;
    endcase
    // A bad access must neither write nor return data
    if (misalign) begin
      lanes = '0;
      data  = '0;
    end
  end
endmodule

// File: rtl/data_mem_bytelane.sv
// Byte-addressable little-endian data memory with sized, extended loads,
// misalignment detection and a Req/Ready, Valid handshake of LAT cycles.
module data_mem_bytelane
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LAT   = 1
) (
  input logic                CLK,
  input logic                RST,
  data_mem_bytelane_if.slave bus
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [1:0] CNT_INIT = 2'((LAT > 1) ? (LAT - 2) : 0);

  if (!lat_ok(LAT)) begin : g_lat_bad
    $error("data_mem_bytelane: LAT must be within 1..4");
  end

  if (AW + 2 < 32) begin : g_unused
    logic unused_addr;
    assign unused_addr = ^bus.Address[31:AW+2];
  end

  // Contents start at zero and survive RST
  logic [3:0][7:0] mem [DEPTH] = '{default: '0};

  state_t          state;
  logic [1:0]      cnt;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic            accept;
  logic [AW-1:0]   idx;
  logic [3:0][7:0] rd_word;
  logic [3:0][7:0] wr_word;
  logic [31:0]     ld_data;
  logic [3:0]      lanes;
  logic            misalign;

  assign bus.Ready = (state == IDLE) || (state == RESP);
  assign accept    = bus.Req & bus.Ready & ~RST;
  assign idx       = bus.Address[AW+1:2];
  assign rd_word   = mem[idx];

  load_align u_align (
    .word     (rd_word),
    .addr_lo  (bus.Address[1:0]),
    .size     (bus.Size),
    .sgn      (bus.Signed),
    .data     (ld_data),
    .lanes    (lanes),
    .misalign (misalign)
  );

  // Replicate store data across lanes; the lane mask picks the right copy
  always_comb begin
    case (bus.Size)
      SIZE_B:  wr_word = {4{bus.WriteData[7:0]}};
      SIZE_H:  wr_word = {2{bus.WriteData[15:0]}};
      default: wr_word = bus.WriteData;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (accept && bus.WriteEnable) begin
      for (int l = 0; l < 4; l++) begin
        if (lanes[l]) mem[idx][l] <= wr_word[l];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          if (cnt == 2'd0) state <= RESP;
          else             cnt   <= cnt - 2'd1;
        end
        RESP:    if (!accept) state <= IDLE;
        default: ;
      endcase
      if (accept) begin
        state   <= (LAT > 1) ? BUSY : RESP;
        cnt     <= CNT_INIT;
        rdata_q <= bus.WriteEnable ? 32'd0 : ld_data;
        err_q   <= misalign;
      end
    end
  end

  assign bus.Valid    = (state == RESP);
  assign bus.ReadData = bus.Valid ? rdata_q : 32'd0;
  assign bus.Error    = bus.Valid & err_q;
endmodule

// File: tb/tb_data_mem_bytelane.sv
// Three memories (LAT 1, 3, 4) driven by directed and random accesses and
// compared against a byte-array model of the memory.
module tb_data_mem_bytelane;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       req = '0, we = '0, sg = '0;
  logic [2:0][1:0]  sz = '0;
  logic [2:0][31:0] addr = '0, wd = '0;
  logic [2:0]       rdy, vld, er;
  logic [2:0][31:0] rd;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    data_mem_bytelane_if bus ();
    assign bus.Req         = req[k];
    assign bus.WriteEnable = we[k];
    assign bus.Size        = sz[k];
    assign bus.Signed      = sg[k];
    assign bus.Address     = addr[k];
    assign bus.WriteData   = wd[k];
    assign rdy[k]          = bus.Ready;
    assign vld[k]          = bus.Valid;
    assign rd[k]           = bus.ReadData;
    assign er[k]           = bus.Error;
    data_mem_bytelane #(.DEPTH(256), .LAT(k == 0 ? 1 : (k == 1 ? 3 : 4))) u_dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
    );
  end

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] mref [3][1024];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: 4*DEPTH bytes, little-endian, addresses wrap at 1024
  task automatic model(input int k, input bit w, input logic [1:0] s, input bit g,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] e_rd, output bit e_er);
    int b, n;
    logic [31:0] v;
    b    = int'(a[9:0]);
    e_er = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    e_rd = '0;
    if (e_er) return;
    n = 1 << int'(s);
    if (w) begin
      for (int i = 0; i < n; i++) mref[k][b+i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mref[k][b+i]) << (8*i));
      if (g && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e_rd = v;
    end
  endtask

  task automatic rand_op(output bit w, output logic [1:0] s, output bit g,
                         output logic [31:0] a, output logic [31:0] d);
    w = 1'($urandom_range(0, 1));
    g = 1'($urandom_range(0, 1));
    s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) begin
      if (s == 2'd1)      a[0]   = 1'b0;
      else if (s == 2'd2) a[1:0] = 2'd0;
    end
    d = $urandom;
  endtask

  // One isolated access: checks Ready/Valid timing, response and clearing
  task automatic xfer(input int k, input bit w, input logic [1:0] s, input bit g,
                      input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
    logic [31:0] e_rd;
    bit e_er;
    int lat;
    lat = lat_of(k);
    got = '0;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; sz[k] = s; sg[k] = g; addr[k] = a; wd[k] = d;
    chk($sformatf("k%0d ready_idle", k), 32'(rdy[k]), 32'd1);
    @(posedge clk);
    model(k, w, s, g, a, d, e_rd, e_er);
    #1 req[k] = 1'b0;
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      chk($sformatf("k%0d valid n%0d", k, n), 32'(vld[k]), 32'(n == lat));
      chk($sformatf("k%0d ready n%0d", k, n), 32'(rdy[k]), 32'(n >= lat));
      if (n == lat) begin
        got = rd[k];
        chk($sformatf("k%0d rdata @%h", k, a), rd[k], e_rd);
        chk($sformatf("k%0d error @%h", k, a), 32'(er[k]), 32'(e_er));
      end else if (n == lat + 1) begin
        chk($sformatf("k%0d rdata_clr", k), rd[k], 32'd0);
        chk($sformatf("k%0d error_clr", k), 32'(er[k]), 32'd0);
      end
    end
  endtask

  // LAT=1 instance with Req held every cycle: one response per cycle
  task automatic burst(input int cnt);
    logic [31:0] q_rd[$];
    bit q_er[$];
    logic [31:0] e_rd, x_rd, d, a;
    bit e_er, x_er, w, g;
    logic [1:0] s;
    for (int i = 0; i <= cnt; i++) begin
      @(negedge clk);
      if (i > 0) begin
        x_rd = q_rd.pop_front();
        x_er = q_er.pop_front();
        chk("burst valid", 32'(vld[0]), 32'd1);
        chk("burst rdata", rd[0], x_rd);
        chk("burst error", 32'(er[0]), 32'(x_er));
      end
      chk("burst ready", 32'(rdy[0]), 32'd1);
      if (i == cnt) begin
        req[0] = 1'b0;
      end else begin
        rand_op(w, s, g, a, d);
        req[0] = 1'b1; we[0] = w; sz[0] = s; sg[0] = g; addr[0] = a; wd[0] = d;
        @(posedge clk);
        model(0, w, s, g, a, d, e_rd, e_er);
        q_rd.push_back(e_rd);
        q_er.push_back(e_er);
      end
    end
    @(negedge clk);
    chk("burst idle valid", 32'(vld[0]), 32'd0);
    chk("burst idle rdata", rd[0], 32'd0);
  endtask

  initial begin
    logic [31:0] got, e1, e2;
    bit ee, w, g;
    logic [1:0] s;
    logic [31:0] a, d;

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 1024; i++) mref[k][i] = 8'h00;

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("k%0d rst ready", k), 32'(rdy[k]), 32'd1);
      chk($sformatf("k%0d rst valid", k), 32'(vld[k]), 32'd0);
      chk($sformatf("k%0d rst rdata", k), rd[k], 32'd0);
      chk($sformatf("k%0d rst error", k), 32'(er[k]), 32'd0);
    end
    rst = 1'b0;

    // Word path, byte/half lanes, misalignment, wrap (LAT=1)
    xfer(0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, got);
    xfer(0, 0, 2'd2, 0, 32'h10, 32'h0, got);
    chk("word load", got, 32'hDEAD_BEEF);
    xfer(0, 1, 2'd2, 0, 32'h10, 32'h0, got);
    xfer(0, 1, 2'd0, 0, 32'h13, 32'h1234_5680, got);
    xfer(0, 0, 2'd2, 0, 32'h10, 32'h0, got);
    chk("byte lane word", got, 32'h8000_0000);
    xfer(0, 0, 2'd0, 1, 32'h13, 32'h0, got);
    chk("signed byte", got, 32'hFFFF_FF80);
    xfer(0, 0, 2'd0, 0, 32'h13, 32'h0, got);
    chk("unsigned byte", got, 32'h0000_0080);
    xfer(0, 0, 2'd1, 1, 32'h12, 32'h0, got);
    chk("signed half", got, 32'hFFFF_8000);
    xfer(0, 1, 2'd2, 0, 32'h12, 32'hFFFF_FFFF, got);
    xfer(0, 0, 2'd1, 0, 32'h11, 32'h0, got);
    xfer(0, 1, 2'd3, 0, 32'h10, 32'hFFFF_FFFF, got);
    xfer(0, 0, 2'd2, 0, 32'h10, 32'h0, got);
    chk("misalign unchanged", got, 32'h8000_0000);
    xfer(0, 1, 2'd2, 0, 32'h400, 32'h0000_1234, got);
    xfer(0, 0, 2'd2, 0, 32'h0, 32'h0, got);
    chk("wrap", got, 32'h0000_1234);

    burst(60);

    // LAT=3 with Req held: second request accepted in the Valid cycle
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'd2; sg[1] = 1'b0; addr[1] = 32'h44; wd[1] = 32'h55AA_1234;
    @(posedge clk);
    model(1, 1, 2'd2, 0, 32'h44, 32'h55AA_1234, e1, ee);
    #1 we[1] = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk($sformatf("held1 valid n%0d", n), 32'(vld[1]), 32'(n == 3));
      chk($sformatf("held1 ready n%0d", n), 32'(rdy[1]), 32'(n == 3));
      if (n == 3) chk("held1 rdata", rd[1], e1);
    end
    @(posedge clk);
    model(1, 0, 2'd2, 0, 32'h44, 32'h0, e2, ee);
    #1 req[1] = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk($sformatf("held2 valid n%0d", n), 32'(vld[1]), 32'(n == 3));
      chk($sformatf("held2 ready n%0d", n), 32'(rdy[1]), 32'(n == 3));
      if (n == 3) begin
        chk("held2 rdata", rd[1], e2);
        chk("held2 const", rd[1], 32'h55AA_1234);
      end
    end

    for (int i = 0; i < 30; i++) begin
      rand_op(w, s, g, a, d);
      xfer(1, w, s, g, a, d, got);
      rand_op(w, s, g, a, d);
      xfer(2, w, s, g, a, d, got);
    end

    // LAT=4 reset mid-transaction: response dropped, store kept
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; sz[2] = 2'd2; sg[2] = 1'b0; addr[2] = 32'h20; wd[2] = 32'hCAFE_F00D;
    @(posedge clk);
    model(2, 1, 2'd2, 0, 32'h20, 32'hCAFE_F00D, e1, ee);
    #1 req[2] = 1'b0;
    @(negedge clk);
    chk("rstmid valid n1", 32'(vld[2]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid ready", 32'(rdy[2]), 32'd1);
    chk("rstmid valid", 32'(vld[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk($sformatf("rstmid no valid %0d", n), 32'(vld[2]), 32'd0);
      chk($sformatf("rstmid ready %0d", n), 32'(rdy[2]), 32'd1);
    end
    xfer(2, 0, 2'd2, 0, 32'h20, 32'h0, got);
    chk("rstmid store kept", got, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
